// File: rtl/pipe_reg_elastic_if.sv
// Handshake bundle for the elastic pipeline register.
// The upstream push side, downstream pop side, flush and occupancy are kept together.
// master drives the stage (producer/consumer side); slave is the buffer itself.
interface pipe_reg_elastic_if #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 2
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              flush;
   logic [CNT_W-1:0]  count;

   modport master (
      output in_valid, in_data, out_ready, flush,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: a small circular buffer between two pipeline stages.
// in_ready and out_valid come only from the registered occupancy, so no ready/valid
// combinational path crosses the stage. out_data is read from the slot at the read
// pointer, which means a pushed entry always takes one cycle to reach the output.
// Flush empties the buffer (pointers back to 0). Reset does the same and also loads
// RST_DATA into slot 0, so the first thing on out_data is a NOP at the reset PC.
module pipe_reg_elastic #(
   parameter int                 DATA_W   = 64,
   parameter int                 DEPTH    = 2,
   parameter logic [DATA_W-1:0]  RST_DATA = DATA_W'({32'h0000_0013, 32'h8000_0000}),
   parameter int                 CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   pipe_reg_elastic_if.slave bus
);

   // A one-entry buffer still needs a one-bit pointer so the storage can be indexed.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wp_q, wp_d;
   logic [PTR_W-1:0]  rp_q, rp_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic in_ready;
   logic out_valid;
   logic push;
   logic pop;

   // Handshake status derived purely from registered occupancy.
   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = mem_q[rp_q];
   assign bus.count     = count_q;

   // Event decode and next-state for pointers and occupancy; flush wins over push/pop.
   always_comb begin
      push    = bus.in_valid && in_ready && !bus.flush;
      pop     = out_valid && bus.out_ready && !bus.flush;
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;

      if (push) begin
         wp_d = (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
      end
      if (pop) begin
         rp_d = (rp_q == PTR_W'(DEPTH - 1)) ? '0 : rp_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (bus.flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end
   end

   // Pointer and occupancy registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   // Payload storage: slot 0 (the read slot after reset) gets RST_DATA, others are
   // written only on a push.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q[0] <= RST_DATA;
      end else if (push) begin
         mem_q[wp_q] <= bus.in_data;
      end
   end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic: DEPTH=2, DEPTH=3 and DEPTH=1 instances
// share clock and reset; each scenario task drives one instance and checks inline.
module tb_pipe_reg_elastic;

   localparam logic [63:0] RST_VAL = 64'h0000_0013_8000_0000;

   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   pipe_reg_elastic_if #(.DATA_W(64), .CNT_W(2)) b2 ();
   pipe_reg_elastic_if #(.DATA_W(64), .CNT_W(2)) b3 ();
   pipe_reg_elastic_if #(.DATA_W(64), .CNT_W(1)) b1 ();

   pipe_reg_elastic #(.DATA_W(64), .DEPTH(2)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   pipe_reg_elastic #(.DATA_W(64), .DEPTH(3)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(b3));
   pipe_reg_elastic #(.DATA_W(64), .DEPTH(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, want finish before 2000000");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total_cnt++; if (b2.count !== 2'd0) $display("FAIL reset_count: got %0d want 0", b2.count); else pass_cnt++;
      total_cnt++; if (b2.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", b2.out_valid); else pass_cnt++;
      total_cnt++; if (b2.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", b2.in_ready); else pass_cnt++;
      total_cnt++; if (b2.out_data !== RST_VAL) $display("FAIL reset_out_data_d2: got %h want %h", b2.out_data, RST_VAL); else pass_cnt++;
      total_cnt++; if (b3.out_data !== RST_VAL) $display("FAIL reset_out_data_d3: got %h want %h", b3.out_data, RST_VAL); else pass_cnt++;
      total_cnt++; if (b1.out_data !== RST_VAL) $display("FAIL reset_out_data_d1: got %h want %h", b1.out_data, RST_VAL); else pass_cnt++;
      $display("reset: count=%0d out_valid=%b in_ready=%b out_data=%h", b2.count, b2.out_valid, b2.in_ready, b2.out_data);
      rst_n = 1'b1;
   endtask

   task automatic test_push_one();
      b2.in_valid  = 1'b1;
      b2.in_data   = 64'hA1;
      b2.out_ready = 1'b0;
      tick();
      total_cnt++; if (b2.out_valid !== 1'b1) $display("FAIL push1_out_valid: got %b want 1", b2.out_valid); else pass_cnt++;
      total_cnt++; if (b2.out_data !== 64'hA1) $display("FAIL push1_out_data: got %h want a1", b2.out_data); else pass_cnt++;
      total_cnt++; if (b2.count !== 2'd1) $display("FAIL push1_count: got %0d want 1", b2.count); else pass_cnt++;
      total_cnt++; if (b2.in_ready !== 1'b1) $display("FAIL push1_in_ready: got %b want 1", b2.in_ready); else pass_cnt++;
      $display("push 0xa1: out_valid=%b out_data=%h count=%0d", b2.out_valid, b2.out_data, b2.count);
   endtask

   task automatic test_fill();
      b2.in_data = 64'hA2;
      tick();
      total_cnt++; if (b2.count !== 2'd2) $display("FAIL fill_count: got %0d want 2", b2.count); else pass_cnt++;
      total_cnt++; if (b2.in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", b2.in_ready); else pass_cnt++;
      $display("push 0xa2: count=%0d in_ready=%b", b2.count, b2.in_ready);
      b2.in_data = 64'hA3;
      tick();
      total_cnt++; if (b2.count !== 2'd2) $display("FAIL full_reject_count: got %0d want 2", b2.count); else pass_cnt++;
      total_cnt++; if (b2.out_data !== 64'hA1) $display("FAIL full_hold_data: got %h want a1", b2.out_data); else pass_cnt++;
      $display("offer 0xa3 while full: count=%0d out_data=%h", b2.count, b2.out_data);
      b2.in_valid  = 1'b0;
      b2.out_ready = 1'b1;
      tick();
      total_cnt++; if (b2.out_data !== 64'hA2) $display("FAIL drain_second: got %h want a2", b2.out_data); else pass_cnt++;
      total_cnt++; if (b2.count !== 2'd1) $display("FAIL drain_count1: got %0d want 1", b2.count); else pass_cnt++;
      $display("pop 0xa1: next out_data=%h count=%0d", b2.out_data, b2.count);
      tick();
      total_cnt++; if (b2.count !== 2'd0) $display("FAIL drain_count0: got %0d want 0", b2.count); else pass_cnt++;
      total_cnt++; if (b2.out_valid !== 1'b0) $display("FAIL drain_out_valid: got %b want 0", b2.out_valid); else pass_cnt++;
      $display("pop 0xa2: count=%0d out_valid=%b", b2.count, b2.out_valid);
      b2.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int nxt  = 1;
      int expv = 1;
      int cyc  = 0;
      int maxc = 0;
      b2.out_ready = 1'b1;
      while (expv <= 100 && cyc < 300) begin
         if (b2.out_valid) begin
            total_cnt++;
            if (b2.out_data !== 64'(expv)) $display("FAIL stream_data: got %0d want %0d", b2.out_data, expv);
            else pass_cnt++;
            expv++;
         end
         if (int'(b2.count) > maxc) maxc = int'(b2.count);
         if (b2.in_valid && b2.in_ready) nxt++;
         b2.in_valid = (nxt <= 100);
         b2.in_data  = 64'(nxt);
         tick();
         cyc++;
      end
      total_cnt++; if (cyc !== 101) $display("FAIL stream_cycles: got %0d want 101", cyc); else pass_cnt++;
      total_cnt++; if (maxc > 1) $display("FAIL stream_max_count: got %0d want <=1", maxc); else pass_cnt++;
      total_cnt++; if (b2.count !== 2'd0) $display("FAIL stream_end_count: got %0d want 0", b2.count); else pass_cnt++;
      $display("stream 1..100: pops=%0d cycles=%0d max_count=%0d", expv - 1, cyc, maxc);
      b2.in_valid  = 1'b0;
      b2.out_ready = 1'b0;
   endtask

   task automatic test_flush();
      bit seen = 1'b0;
      // Move the pointers off zero before flushing: entries 0x11, 0x22 in, pop 0x11, push 0x33.
      b2.in_valid = 1'b1; b2.in_data = 64'h11;
      tick();
      b2.in_data = 64'h22;
      tick();
      b2.in_valid = 1'b0; b2.out_ready = 1'b1;
      tick();
      b2.out_ready = 1'b0; b2.in_valid = 1'b1; b2.in_data = 64'h33;
      tick();
      total_cnt++; if (b2.count !== 2'd2) $display("FAIL preflush_count: got %0d want 2", b2.count); else pass_cnt++;
      b2.flush = 1'b1; b2.in_data = 64'hFF;
      tick();
      b2.flush = 1'b0; b2.in_valid = 1'b0;
      total_cnt++; if (b2.count !== 2'd0) $display("FAIL flush_count: got %0d want 0", b2.count); else pass_cnt++;
      total_cnt++; if (b2.out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", b2.out_valid); else pass_cnt++;
      total_cnt++; if (b2.in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", b2.in_ready); else pass_cnt++;
      $display("flush with push 0xff: count=%0d out_valid=%b in_ready=%b", b2.count, b2.out_valid, b2.in_ready);
      b2.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (b2.out_valid) seen = 1'b1;
         tick();
      end
      total_cnt++; if (seen !== 1'b0) $display("FAIL flush_ff_leaked: got out_valid after flush want none"); else pass_cnt++;
      b2.out_ready = 1'b0; b2.in_valid = 1'b1; b2.in_data = 64'h44;
      tick();
      b2.in_valid = 1'b0;
      total_cnt++; if (b2.out_data !== 64'h44) $display("FAIL postflush_data: got %h want 44", b2.out_data); else pass_cnt++;
      total_cnt++; if (b2.count !== 2'd1) $display("FAIL postflush_count: got %0d want 1", b2.count); else pass_cnt++;
      $display("push 0x44 after flush: out_data=%h count=%0d", b2.out_data, b2.count);
      b2.out_ready = 1'b1;
      tick();
      b2.out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      logic [15:0] pat = 16'b1011_0110_1010_0000;
      int  nxt  = 1;
      int  expv = 1;
      int  mcnt = 0;
      int  cyc  = 0;
      bit  do_push;
      bit  do_pop;
      while (expv <= 10 && cyc < 100) begin
         b3.out_ready = pat[cyc % 16];
         b3.in_valid  = (nxt <= 10);
         b3.in_data   = 64'(nxt);
         do_pop  = b3.out_valid && b3.out_ready;
         do_push = b3.in_valid && b3.in_ready;
         if (do_pop) begin
            total_cnt++;
            if (b3.out_data !== 64'(expv)) $display("FAIL wrap_data: got %0d want %0d", b3.out_data, expv);
            else pass_cnt++;
            expv++;
         end
         if (do_push) nxt++;
         mcnt = mcnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
         tick();
         cyc++;
         total_cnt++; if (b3.count !== 2'(mcnt)) $display("FAIL wrap_count: got %0d want %0d", b3.count, mcnt); else pass_cnt++;
         total_cnt++; if (b3.in_ready !== (mcnt < 3)) $display("FAIL wrap_in_ready: got %b want %b", b3.in_ready, (mcnt < 3)); else pass_cnt++;
      end
      total_cnt++; if (expv !== 11) $display("FAIL wrap_timeout: got %0d pops want 10", expv - 1); else pass_cnt++;
      $display("depth3 wrap: pops=%0d cycles=%0d", expv - 1, cyc);
      b3.in_valid  = 1'b0;
      b3.out_ready = 1'b0;
   endtask

   task automatic test_depth1();
      int nxt  = 1;
      int expv = 1;
      b1.in_valid  = 1'b1;
      b1.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         total_cnt++; if (b1.out_valid !== (c % 2 == 1)) $display("FAIL d1_out_valid: cycle %0d got %b want %b", c, b1.out_valid, (c % 2 == 1)); else pass_cnt++;
         total_cnt++; if (b1.in_ready !== (c % 2 == 0)) $display("FAIL d1_in_ready: cycle %0d got %b want %b", c, b1.in_ready, (c % 2 == 0)); else pass_cnt++;
         if (b1.out_valid) begin
            total_cnt++;
            if (b1.out_data !== 64'(expv)) $display("FAIL d1_data: got %0d want %0d", b1.out_data, expv);
            else pass_cnt++;
            expv++;
         end
         b1.in_data = 64'(nxt);
         if (b1.in_ready) nxt++;
         if (c == 7) rst_n = 1'b0;
         tick();
      end
      total_cnt++; if (b1.count !== 1'd0) $display("FAIL d1_rst_count: got %0d want 0", b1.count); else pass_cnt++;
      total_cnt++; if (b1.out_valid !== 1'b0) $display("FAIL d1_rst_out_valid: got %b want 0", b1.out_valid); else pass_cnt++;
      total_cnt++; if (b1.in_ready !== 1'b1) $display("FAIL d1_rst_in_ready: got %b want 1", b1.in_ready); else pass_cnt++;
      total_cnt++; if (b1.out_data !== RST_VAL) $display("FAIL d1_rst_out_data: got %h want %h", b1.out_data, RST_VAL); else pass_cnt++;
      $display("depth1 alt stream + mid reset: pops=%0d count=%0d out_data=%h", expv - 1, b1.count, b1.out_data);
      rst_n = 1'b1;
      b1.in_valid  = 1'b0;
      b1.out_ready = 1'b0;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n     = 1'b0;
      b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0; b2.flush = 1'b0;
      b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0; b3.flush = 1'b0;
      b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0; b1.flush = 1'b0;

      test_reset();
      test_push_one();
      test_fill();
      test_back_to_back();
      test_flush();
      test_wrap();
      test_depth1();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pipe_reg_elastic.md
PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

Interface
REQ-001 Parameter: DATA_W, default 64, payload width in bits (pc concatenated with inst for the fetch-to-decode stage).
REQ-002 Parameter: DEPTH, default 2, number of buffer entries; legal range 1..16.
REQ-003 Parameter: RST_DATA, default {32'h0000_0013, 32'h8000_0000}, DATA_W bits, out_data value after reset (NOP instruction, reset PC).
REQ-004 Parameter: CNT_W, default $clog2(DEPTH+1), width of the occupancy counter.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  upstream offers in_data this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 in_ready  output  1  buffer can accept a push this cycle.
REQ-010 out_valid  output  1  head entry is presented on out_data.
REQ-011 out_data  output  DATA_W  head payload.
REQ-012 out_ready  input  1  downstream consumes the head this cycle.
REQ-013 flush  input  1  discard all entries (branch redirect / exception).
REQ-014 count  output  CNT_W  current number of valid entries.

Function
REQ-015 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-016 in_ready SHALL equal (count < DEPTH) and SHALL be a function of registered state only, with no combinational path from out_ready or in_valid.
REQ-017 out_valid SHALL equal (count != 0) and SHALL be a function of registered state only.
REQ-018 Storage is a circular buffer with write pointer wp and read pointer rp; each pointer increments on its event and wraps from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-019 count update per cycle: +1 on push only, -1 on pop only, unchanged when both or neither occur.
REQ-020 Latency: a push into an empty buffer SHALL appear on out_valid/out_data on the next cycle; data is never forwarded combinationally from input to output.
REQ-021 Ordering: entries SHALL leave in push order with no loss or duplication.
REQ-022 Throughput: for DEPTH >= 2, one transfer per cycle is sustained while out_ready is held at 1.
REQ-023 Throughput: DEPTH = 1 is limited to one transfer every 2 cycles, because a full buffer cannot accept while popping.
REQ-024 Simultaneous push and pop when count == DEPTH cannot occur, since in_ready = 0.
REQ-025 Simultaneous push and pop when count == 0 cannot occur, since out_valid = 0.
REQ-026 Flush: on the next edge count = 0 and wp = rp = 0; flush overrides a concurrent push or pop in the same cycle.
REQ-027 Flush: in_ready = 1 and out_valid = 0 in the cycle after a flush.
REQ-028 Payload holding: out_data SHALL hold its value while out_valid && !out_ready.
REQ-029 Payload when empty: out_data SHALL show the storage slot at rp, with no required value except after reset.
REQ-030 The upstream SHALL keep in_data stable while in_valid && !in_ready; the block does not check this.

Reset
REQ-031 While rst_n = 0 at a rising edge: count = 0, wp = rp = 0, out_valid = 0, in_ready = 1, and the entry at rp (out_data) = RST_DATA.
REQ-032 Reset SHALL take priority over flush, push and pop.
REQ-033 Reset asserted mid-stream SHALL discard all entries.
REQ-034 Storage slots other than rp need no reset.

Verification
REQ-035 Scenario: DEPTH=2, reset, then push 0xA1 with out_ready=0 -> next cycle out_valid=1, out_data=0xA1, count=1, in_ready=1.
REQ-036 Scenario: DEPTH=2, push 0xA1 then 0xA2 with out_ready=0 -> count=2, in_ready=0; a third offer 0xA3 is not accepted; out_ready=1 for 2 cycles -> outputs 0xA1, 0xA2 in order, then count=0.
REQ-037 Scenario: DEPTH=2, continuous in_valid=1 and out_ready=1 with data 1..100 -> 100 pops in order, one per cycle after 1-cycle fill latency, count never exceeds 1.
REQ-038 Scenario: DEPTH=3, 10 pushes interleaved with random out_ready -> pointers wrap 2->0, output order 1..10 preserved.
REQ-039 Scenario: count=2, flush=1 together with in_valid=1 (data 0xFF) -> next cycle count=0, out_valid=0, and 0xFF is never output.
REQ-040 Scenario: DEPTH=1, continuous in_valid=1 and out_ready=1 -> a transfer every second cycle; rst_n=0 mid-stream -> next cycle count=0 and out_data=RST_DATA.
